// File: rtl/md_unit_if.sv
// Handshake/result bundle between the EX-stage issue logic and the
// multiply/divide unit.
interface md_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, A, B, input  Busy, HI, LO);
  modport slave  (input  Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO, and the architectural HI/LO registers.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave md
);
  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } md_op_e;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  md_op_e        op_q,   op_d;
  logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  // Results are formed from the latched operands only, so mid-op input
  // changes cannot leak into the writeback.
  logic [63:0] prod_s, prod_u;
  logic        dsgn;
  logic [31:0] a_mag, b_mag, dvs, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case
    // and gives truncation toward zero with remainder sign = dividend sign.
    dsgn  = (op_q == OP_DIV);
    a_mag = (dsgn && a_q[31]) ? -a_q : a_q;
    b_mag = (dsgn && b_q[31]) ? -b_q : b_q;
    dvs   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / dvs;
    r_mag = a_mag % dvs;
    quot  = (dsgn && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    rem   = (dsgn && a_q[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (!busy_q) begin
      if (md.Start) begin
        case (md_op_e'(md.MDOp))
          OP_MULT, OP_MULTU: begin
            a_d    = md.A;
            b_d    = md.B;
            op_d   = md_op_e'(md.MDOp);
            cnt_d  = CW'(MULT_CYCLES);
            busy_d = 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            a_d    = md.A;
            b_d    = md.B;
            op_d   = md_op_e'(md.MDOp);
            cnt_d  = CW'(DIV_CYCLES);
            busy_d = 1'b1;
          end
          OP_MTHI: hi_d = md.A;
          OP_MTLO: lo_d = md.A;
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        case (op_q)
          OP_MULT:  begin hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
          OP_MULTU: begin hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
          OP_DIV, OP_DIVU: begin
            if (b_q != 32'd0) begin
              hi_d = rem;
              lo_d = quot;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign md.Busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
endmodule
